// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants for the write-back stage
package cpu_pkg;

  localparam int DW          = 32;
  localparam int NREG        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int CNTW        = 8;

  // Bit positions inside the MEM/WB write-back control field
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/wb_regfile_gpr_array.sv
// rtl/wb_regfile_gpr_array.sv - general-purpose register storage, two async reads, r0 hardwired zero
module gpr_array
  import cpu_pkg::REG_ADDR_W;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int DW   = cpu_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DW-1:0]         rdata_a_o,
  output logic [DW-1:0]         rdata_b_o
);

  logic [DW-1:0] regs_q [NREG];

  // r0 is guarded on both write and read so its storage never matters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage: data select, overflow gating, register commit, bypass, exception count
module wb_regfile
  import cpu_pkg::REG_ADDR_W, cpu_pkg::WB_REGWRITE, cpu_pkg::WB_MEMTOREG;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int DW   = cpu_pkg::DW,
  parameter int CNTW = cpu_pkg::CNTW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_WB,
  input  logic                  i_overflow,
  input  logic [DW-1:0]         i_Dm,
  input  logic [DW-1:0]         i_result,
  input  logic [REG_ADDR_W-1:0] i_Rw,
  input  logic [REG_ADDR_W-1:0] i_Ra,
  input  logic [REG_ADDR_W-1:0] i_Rb,
  output logic [DW-1:0]         o_busA,
  output logic [DW-1:0]         o_busB,
  output logic                  o_wr_en,
  output logic [REG_ADDR_W-1:0] o_wr_addr,
  output logic [DW-1:0]         o_wr_data,
  output logic                  o_exc,
  output logic [CNTW-1:0]       o_exc_cnt
);

  logic            rw_nonzero;
  logic            we;
  logic            exc_cond;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rd_a;
  logic [DW-1:0]   rd_b;
  logic            exc_d, exc_q;
  logic [CNTW-1:0] exc_cnt_d, exc_cnt_q;

  assign rw_nonzero = (i_Rw != '0);
  assign wdata      = i_WB[WB_MEMTOREG] ? i_Dm : i_result;
  assign we         = i_WB[WB_REGWRITE] & ~i_overflow & rw_nonzero;
  assign exc_cond   = i_WB[WB_REGWRITE] &  i_overflow & rw_nonzero;

  assign o_wr_en   = we;
  assign o_wr_addr = i_Rw;
  assign o_wr_data = wdata;

  gpr_array #(
    .NREG (NREG),
    .DW   (DW)
  ) u_gpr (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .waddr_i   (i_Rw),
    .wdata_i   (wdata),
    .raddr_a_i (i_Ra),
    .raddr_b_i (i_Rb),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  // Same-cycle bypass so the ID stage sees the value being committed now
  assign o_busA = (i_Ra == '0) ? '0 : (we && (i_Ra == i_Rw)) ? wdata : rd_a;
  assign o_busB = (i_Rb == '0) ? '0 : (we && (i_Rb == i_Rw)) ? wdata : rd_b;

  always_comb begin
    exc_d     = exc_cond;
    exc_cnt_d = exc_cnt_q;
    if (exc_cond && (exc_cnt_q != {CNTW{1'b1}})) begin
      exc_cnt_d = exc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q     <= 1'b0;
      exc_cnt_q <= '0;
    end else begin
      exc_q     <= exc_d;
      exc_cnt_q <= exc_cnt_d;
    end
  end

  assign o_exc     = exc_q;
  assign o_exc_cnt = exc_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile against a behavioural model
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_WB;
  logic        i_overflow;
  logic [31:0] i_Dm;
  logic [31:0] i_result;
  logic [4:0]  i_Rw;
  logic [4:0]  i_Ra;
  logic [4:0]  i_Rb;
  logic [31:0] o_busA;
  logic [31:0] o_busB;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_exc;
  logic [7:0]  o_exc_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .i_WB       (i_WB),
    .i_overflow (i_overflow),
    .i_Dm       (i_Dm),
    .i_result   (i_result),
    .i_Rw       (i_Rw),
    .i_Ra       (i_Ra),
    .i_Rb       (i_Rb),
    .o_busA     (o_busA),
    .o_busB     (o_busB),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_exc      (o_exc),
    .o_exc_cnt  (o_exc_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Architectural model: plain array of register values plus exception bookkeeping
  logic [31:0] m_regs [32];
  bit          m_exc;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wdata();
    return i_WB[0] ? i_Dm : i_result;
  endfunction

  function automatic bit m_we();
    return i_WB[1] && !i_overflow && (i_Rw != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == i_Rw) return m_wdata();
    return m_regs[a];
  endfunction

  // Drive one cycle of inputs and compare every output against the model
  task automatic drive(input bit r, input logic [1:0] wb, input bit ovf, input logic [31:0] dm,
                       input logic [31:0] res, input logic [4:0] rw, input logic [4:0] ra,
                       input logic [4:0] rb);
    rst = r; i_WB = wb; i_overflow = ovf; i_Dm = dm; i_result = res;
    i_Rw = rw; i_Ra = ra; i_Rb = rb;
    #2;
    check("wr_en",   {31'b0, o_wr_en}, {31'b0, m_we()});
    check("wr_addr", {27'b0, o_wr_addr}, {27'b0, rw});
    check("wr_data", o_wr_data, m_wdata());
    check("busA",    o_busA, m_read(ra));
    check("busB",    o_busB, m_read(rb));
    check("exc",     {31'b0, o_exc}, {31'b0, m_exc});
    check("exc_cnt", {24'b0, o_exc_cnt}, m_cnt[31:0]);
  endtask

  task automatic tick();
    bit cond;
    @(posedge clk);
    cond = i_WB[1] && i_overflow && (i_Rw != 0);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_exc = 0;
      m_cnt = 0;
    end else begin
      if (m_we()) m_regs[i_Rw] = m_wdata();
      m_exc = cond;
      if (cond && m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_exc = 0;
    m_cnt = 0;

    // First reset cycle: state is still unknown, so no comparisons yet
    rst = 1; i_WB = 0; i_overflow = 0; i_Dm = 0; i_result = 0; i_Rw = 0; i_Ra = 5; i_Rb = 31;
    @(posedge clk); #1;
    drive(1, 2'b00, 0, 0, 0, 0, 5, 31); tick();
    drive(0, 2'b00, 0, 0, 0, 0, 5, 31);
    check("rst_busA", o_busA, 32'h0);
    check("rst_busB", o_busB, 32'h0);
    check("rst_cnt", {24'b0, o_exc_cnt}, 32'h0);
    tick();

    // ALU write with same-cycle bypass
    drive(0, 2'b10, 0, 32'h0, 32'h1234_5678, 8, 8, 0);
    check("alu_bypass", o_busA, 32'h1234_5678);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0, 8, 8);
    check("alu_stored", o_busA, 32'h1234_5678);
    tick();

    // Load select
    drive(0, 2'b11, 0, 32'hDEAD_BEEF, 32'h1, 3, 0, 0);
    check("load_wdata", o_wr_data, 32'hDEAD_BEEF);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0, 3, 3);
    check("load_stored", o_busB, 32'hDEAD_BEEF);
    tick();

    // r0 protection
    drive(0, 2'b10, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    check("r0_we", {31'b0, o_wr_en}, 32'h0);
    check("r0_bus", o_busA, 32'h0);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    check("r0_after", o_busA, 32'h0);
    check("r0_noexc", {31'b0, o_exc}, 32'h0);
    tick();

    // Overflow suppression
    drive(0, 2'b10, 0, 0, 32'h11, 9, 0, 0); tick();
    drive(0, 2'b10, 1, 0, 32'h8000_0000, 9, 9, 0);
    check("ovf_nobypass", o_busA, 32'h11);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0, 9, 0);
    check("ovf_r9", o_busA, 32'h11);
    check("ovf_exc", {31'b0, o_exc}, 32'h1);
    check("ovf_cnt", {24'b0, o_exc_cnt}, 32'h1);
    tick();
    drive(0, 2'b00, 1, 0, 0, 9, 9, 0);
    check("ovf_pulse_end", {31'b0, o_exc}, 32'h0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(0, 2'b10, 1, 0, 32'h8000_0000, 9, 9, 0); tick();
    end
    drive(0, 2'b00, 0, 0, 0, 0, 9, 0);
    check("cnt_sat", {24'b0, o_exc_cnt}, 32'd255);
    tick();

    // Reset mid-operation with an exception pulse pending
    drive(0, 2'b10, 0, 0, 32'h77, 4, 0, 0); tick();
    drive(0, 2'b10, 1, 0, 32'h1, 7, 0, 0); tick();
    drive(1, 2'b10, 0, 0, 32'hAAAA, 4, 4, 0);
    check("rst_bypass", o_busA, 32'hAAAA);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0, 4, 0);
    check("rst_r4", o_busA, 32'h0);
    check("rst_exc", {31'b0, o_exc}, 32'h0);
    check("rst_cnt2", {24'b0, o_exc_cnt}, 32'h0);
    tick();
    drive(0, 2'b10, 0, 0, 32'h5, 4, 0, 0); tick();
    drive(0, 2'b00, 0, 0, 0, 0, 4, 4);
    check("post_rst_r4", o_busA, 32'h5);
    tick();

    // Randomized traffic, addresses biased toward the write target to exercise bypass
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rw, ra, rb;
      rw = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 59) == 0, 2'($urandom), $urandom_range(0, 3) == 0,
            $urandom, $urandom, rw, ra, rb);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
